equiv_check_engine: RTL and testbench

Parametrised self-checking equivalence engine for post-route verification. It drives every input vector of an IN_W-bit combinational design under test into both the golden RTL and the post-route netlist, waits a settle interval, and compares the two output buses. It counts mismatches and captures the first failing vector. It replaces hand-written per-vector stimulus/compare sequences in post-route benches and is sized from parameters, so one engine serves every small combinational testcase.

---
 rtl/equiv_check_engine.sv | 114 +++++++++++
 tb/tb_equiv_check_engine.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/equiv_check_engine.sv
// Exhaustive equivalence engine: sweeps all IN_W-bit vectors into golden/netlist and compares.
// Optional EQCHK_FAIL_STOP_EN: stop at the first mismatching vector.
module equiv_check_engine #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] golden_out,
  input  logic [OUT_W-1:0] netlist_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IN_W:0]    mismatch_cnt,
  output logic             first_fail_valid,
  output logic [IN_W-1:0]  first_fail_vec
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    COMPARE,
    DONE
  } state_t;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   SLAST = CW'(SETTLE - 1);
  localparam logic [IN_W-1:0] VLAST = {IN_W{1'b1}};
  localparam logic [IN_W:0]   CMAX  = {1'b1, {IN_W{1'b0}}};

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic          mm;
  logic          last;

  // 4-state compare: X/Z on either side is a mismatch
  assign mm   = (golden_out !== netlist_out);
  assign last = (stim == VLAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = APPLY;
      APPLY:   if (cnt == SLAST) nxt = COMPARE;
`ifdef EQCHK_FAIL_STOP_EN
      COMPARE: nxt = (mm || last) ? DONE : APPLY;
`else
      COMPARE: nxt = last ? DONE : APPLY;
`endif
      DONE:    if (start) nxt = APPLY;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == APPLY) || (state == COMPARE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim             <= '0;
      cnt              <= '0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            stim             <= '0;
            cnt              <= '0;
            pass             <= 1'b0;
            mismatch_cnt     <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
          end
        end
        APPLY: cnt <= cnt + 1'b1;
        COMPARE: begin
          cnt <= '0;
          if (mm) begin
            if (mismatch_cnt != CMAX)
              mismatch_cnt <= mismatch_cnt + 1'b1;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_vec   <= stim;
            end
          end
`ifdef EQCHK_FAIL_STOP_EN
          if (mm)        pass <= 1'b0;
          else if (last) pass <= (mismatch_cnt == '0);
          else           stim <= stim + 1'b1;
`else
          if (last) pass <= (mismatch_cnt == '0) && !mm;
          else      stim <= stim + 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_equiv_check_engine.sv
// Directed bench for equiv_check_engine: AND2 vs AND2/OR2/X-fault, plus
// restart-while-busy and async reset on a 3-bit, SETTLE=3 instance.
module tb_equiv_check_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start2 = 1'b0;
  logic start3 = 1'b0;
  int   mode = 0;
  logic xv;

  logic [1:0] stim2;
  logic       g2, n2;
  logic       busy2, done2, pass2, ffv2;
  logic [2:0] cnt2;
  logic [1:0] ffvec2;

  logic [2:0] stim3;
  logic [1:0] g3, n3;
  logic       busy3, done3, pass3, ffv3;
  logic [3:0] cnt3;
  logic [2:0] ffvec3;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign g2 = &stim2;
  assign n2 = (mode == 1) ? |stim2 :
              (mode == 2 && stim2 == 2'd3) ? xv : &stim2;
  assign g3 = {^stim3, &stim3};
  assign n3 = {^stim3, &stim3};

  equiv_check_engine #(.IN_W(2), .OUT_W(1), .SETTLE(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .stim(stim2),
    .golden_out(g2), .netlist_out(n2), .busy(busy2), .done(done2),
    .pass(pass2), .mismatch_cnt(cnt2), .first_fail_valid(ffv2),
    .first_fail_vec(ffvec2)
  );

  equiv_check_engine #(.IN_W(3), .OUT_W(2), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .stim(stim3),
    .golden_out(g3), .netlist_out(n3), .busy(busy3), .done(done3),
    .pass(pass3), .mismatch_cnt(cnt3), .first_fail_valid(ffv3),
    .first_fail_vec(ffvec3)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run2(input string tag, input int en, input logic [1:0] es,
                      input logic [2:0] ec, input logic ev,
                      input logic [1:0] evec, input logic ep);
    int n;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    chk({tag, "_busy0"}, busy2, 1);
    chk({tag, "_done0"}, done2, 0);
    chk({tag, "_stim0"}, stim2, 0);
    chk({tag, "_cnt0"}, cnt2, 0);
    chk({tag, "_ffv0"}, ffv2, 0);
    n = 0;
    while (!done2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_cycles"}, n, en);
    chk({tag, "_busy"}, busy2, 0);
    chk({tag, "_stim"}, stim2, es);
    chk({tag, "_cnt"}, cnt2, ec);
    chk({tag, "_ffv"}, ffv2, ev);
    if (ev) chk({tag, "_ffvec"}, ffvec2, evec);
    chk({tag, "_pass"}, pass2, ep);
  endtask

  initial begin
    logic mmx;
    int   n;
    xv  = 1'bx;
    mmx = (xv !== 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stim2", stim2, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_done2", done2, 0);
    chk("rst_pass2", pass2, 0);
    chk("rst_cnt2", cnt2, 0);
    chk("rst_ffv2", ffv2, 0);
    chk("rst_ffvec2", ffvec2, 0);
    chk("rst_busy3", busy3, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    mode = 0;
    run2("and", 8, 2'd3, 3'd0, 1'b0, 2'd0, 1'b1);
    mode = 1;
`ifdef EQCHK_FAIL_STOP_EN
    run2("or", 4, 2'd1, 3'd1, 1'b1, 2'd1, 1'b0);
`else
    run2("or", 8, 2'd3, 3'd2, 1'b1, 2'd1, 1'b0);
`endif
    mode = 2;
    run2("xflt", 8, 2'd3, {2'b0, mmx}, mmx, 2'd3, !mmx);
    mode = 0;
    run2("and2", 8, 2'd3, 3'd0, 1'b0, 2'd0, 1'b1);

    start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    repeat (4) @(posedge clk);
    #1 start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    chk("ign_busy", busy3, 1);
    chk("ign_stim", stim3, 1);
    chk("ign_cnt", cnt3, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("ign_stim2", stim3, 2);
    #3 rst = 1'b1;
    #1;
    chk("arst_stim3", stim3, 0);
    chk("arst_busy3", busy3, 0);
    chk("arst_done3", done3, 0);
    chk("arst_pass3", pass3, 0);
    chk("arst_done2", done2, 0);
    chk("arst_pass2", pass2, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    chk("r3_busy0", busy3, 1);
    n = 0;
    while (!done3 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("r3_cycles", n, 32);
    chk("r3_busy", busy3, 0);
    chk("r3_stim", stim3, 7);
    chk("r3_cnt", cnt3, 0);
    chk("r3_ffv", ffv3, 0);
    chk("r3_pass", pass3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
